// File: rtl/qsys_serial_pkg.sv
// Shared types and constants for the serial Avalon client: frame layout, timeout limit, FSM states.
package qsys_serial_pkg;

   localparam int FRAME_W     = 65;
   localparam int ADDR_W      = 8;
   localparam int DATA_W      = 32;
   localparam int TIMEOUT_MAX = 255;
   localparam logic [DATA_W-1:0] ERR_DATA = 32'hDEADBEEF;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SHIFT    = 3'd1,
      WAIT_RDY = 3'd2,
      RECV     = 3'd3,
      DONE     = 3'd4
   } state_t;

   // bit64 = write flag, bits63:32 = zero-extended address, bits31:0 = data (0 for reads)
   function automatic logic [FRAME_W-1:0] build_frame(input logic              wr,
                                                      input logic [ADDR_W-1:0] addr,
                                                      input logic [DATA_W-1:0] wdata);
      build_frame = {wr, {(DATA_W-ADDR_W){1'b0}}, addr, wr ? wdata : {DATA_W{1'b0}}};
   endfunction

endpackage

// File: rtl/qsys_serial_shifter.sv
// MSB-first shift register with parallel load; serves both the outgoing frame and the return word.
module qsys_serial_shifter
   import qsys_serial_pkg::*;
#(
   parameter int W = DATA_W
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  logic [W-1:0] load_data,
   input  logic         shift_en,
   input  logic         sin,
   output logic         sout,
   output logic [W-1:0] data
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data <= '0;
      end else if (load) begin
         data <= load_data;
      end else if (shift_en) begin
         data <= {data[W-2:0], sin};
      end
   end

   assign sout = data[W-1];

endmodule

// File: rtl/qsys_serial_client.sv
// Avalon slave that forwards each access as a 65-bit serial frame and collects a 32-bit reply.
// Optional build macro SERIAL_TIMEOUT_EN adds a reply timeout and the sticky error output.
module qsys_serial_client
   import qsys_serial_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] avs_S1_address,
   input  logic              avs_S1_read,
   input  logic              avs_S1_write,
   input  logic [DATA_W-1:0] avs_S1_writedata,
   output logic [DATA_W-1:0] avs_S1_readdata,
   output logic              avs_S1_waitrequest,
   output logic              sle,
   output logic              sdo,
   input  logic              sdi,
   input  logic              srdy,
`ifdef SERIAL_TIMEOUT_EN
   output logic              error,
`endif
   output state_t            state_dbg
);

   // Handshake: a request (read or write) is held by the master while waitrequest is high;
   // it completes in the single cycle where the request is high and waitrequest is low (DONE).
   // On the host side each cycle with srdy high carries exactly one valid return bit on sdi.

   state_t              state, next_state;
   logic [6:0]          shift_cnt;
   logic [4:0]          bit_cnt;
   logic                is_wr_q;
   logic [DATA_W-1:0]   readdata_q;
   logic                frame_sout;
   logic [FRAME_W-1:0]  frame_par_unused;
   logic [DATA_W-1:0]   ret_data;
   logic                ret_sout_unused;
   logic                req, accept, in_wait, capture, last_bit, timeout_hit;

   assign req      = avs_S1_read | avs_S1_write;
   assign accept   = (state == IDLE) && req;
   assign in_wait  = (state == WAIT_RDY) || (state == RECV);
   assign capture  = in_wait && srdy;
   assign last_bit = (state == RECV) && srdy && (bit_cnt == 5'd31);

   qsys_serial_shifter #(.W(FRAME_W)) u_frame (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (accept),
      .load_data (build_frame(avs_S1_write, avs_S1_address, avs_S1_writedata)),
      .shift_en  ((state == SHIFT) && (shift_cnt != 7'd0)),
      .sin       (1'b0),
      .sout      (frame_sout),
      .data      (frame_par_unused)
   );

   qsys_serial_shifter #(.W(DATA_W)) u_ret (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (accept),
      .load_data ({DATA_W{1'b0}}),
      .shift_en  (capture),
      .sin       (sdi),
      .sout      (ret_sout_unused),
      .data      (ret_data)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:     if (req) next_state = SHIFT;
         SHIFT:    if (shift_cnt == 7'(FRAME_W)) next_state = WAIT_RDY;
         WAIT_RDY: begin
            if (srdy) next_state = RECV;
            else if (timeout_hit) next_state = DONE;
         end
         RECV:     if (last_bit || timeout_hit) next_state = DONE;
         DONE:     next_state = IDLE;
         default:  next_state = IDLE;
      endcase
   end

   // C0 is a lead-in cycle with sdo low; C65 drops sle while sdo still carries frame bit 0
   always_comb begin
      sle                = 1'b0;
      sdo                = 1'b0;
      avs_S1_waitrequest = req && (state != DONE);
      if (state == SHIFT) begin
         sle = (shift_cnt != 7'(FRAME_W));
         sdo = (shift_cnt != 7'd0) ? frame_sout : 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shift_cnt  <= '0;
         bit_cnt    <= '0;
         is_wr_q    <= 1'b0;
         readdata_q <= '0;
      end else begin
         if (accept) begin
            shift_cnt <= '0;
            bit_cnt   <= '0;
            is_wr_q   <= avs_S1_write;
         end else begin
            if (state == SHIFT) shift_cnt <= shift_cnt + 7'd1;
            if (capture)        bit_cnt   <= bit_cnt + 5'd1;
         end
         if (timeout_hit) begin
            readdata_q <= ERR_DATA;
         end else if (last_bit && !is_wr_q) begin
            readdata_q <= {ret_data[DATA_W-2:0], sdi};
         end
      end
   end

`ifdef SERIAL_TIMEOUT_EN
   logic [7:0] to_cnt;
   logic       error_q;

   // The counter reaches TIMEOUT_MAX on the same edge that moves the FSM to DONE
   assign timeout_hit = in_wait && !srdy && (to_cnt == 8'(TIMEOUT_MAX - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         to_cnt  <= '0;
         error_q <= 1'b0;
      end else begin
         if (!in_wait || srdy) to_cnt <= '0;
         else                  to_cnt <= to_cnt + 8'd1;
         if (accept)           error_q <= 1'b0;
         else if (timeout_hit) error_q <= 1'b1;
      end
   end

   assign error = error_q;
`else
   assign timeout_hit = 1'b0;
`endif

   assign avs_S1_readdata = readdata_q;
   assign state_dbg       = state;

endmodule
